// File: rtl/ps2_mouse_ctrl_if.sv
// ----------------------------------------------------------------------------
// ps2_mouse_ctrl_if
//   Bundles the signals between the PS/2 mouse controller, the PS/2 rx/tx pair
//   upstream and the cursor/brush logic downstream.
//
//   rx_data_i   [7:0]  byte from the PS/2 receiver
//   rx_done_i          one-cycle strobe, rx_data_i valid
//   tx_done_i          one-cycle strobe, transmitter finished a byte
//   tx_en_o            one-cycle request to transmit tx_data_o
//   tx_data_o   [7:0]  byte to transmit (always the enable command)
//   xm_o        [8:0]  X movement, two's complement
//   ym_o        [8:0]  Y movement, two's complement
//   btn_o       [2:0]  {middle, right, left}
//   init_done_o        device acknowledged the enable command
//   done_o             one-cycle strobe, xm_o/ym_o/btn_o updated
//
//   master : the controller side
//   slave  : the environment side (rx/tx pair and packet consumer)
// ----------------------------------------------------------------------------
interface ps2_mouse_ctrl_if;
  logic [7:0] rx_data_i;
  logic       rx_done_i;
  logic       tx_done_i;
  logic       tx_en_o;
  logic [7:0] tx_data_o;
  logic [8:0] xm_o;
  logic [8:0] ym_o;
  logic [2:0] btn_o;
  logic       init_done_o;
  logic       done_o;

  modport master (
    input  rx_data_i,
    input  rx_done_i,
    input  tx_done_i,
    output tx_en_o,
    output tx_data_o,
    output xm_o,
    output ym_o,
    output btn_o,
    output init_done_o,
    output done_o
  );

  modport slave (
    output rx_data_i,
    output rx_done_i,
    output tx_done_i,
    input  tx_en_o,
    input  tx_data_o,
    input  xm_o,
    input  ym_o,
    input  btn_o,
    input  init_done_o,
    input  done_o
  );
endinterface

// File: rtl/ps2_mouse_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_mouse_ctrl
//   PS/2 mouse controller sitting directly after the PS/2 rx/tx pair.
//   After reset it transmits the "enable data reporting" command and waits for
//   the device ACK, resending on timeout. Once acknowledged it assembles the
//   3-byte stream packets into signed 9-bit X/Y deltas plus button states and
//   emits a one-cycle done_o pulse per packet.
//
//   clk_i    system clock
//   reset_i  asynchronous, active-high reset
//   bus      ps2_mouse_ctrl_if.master (rx/tx handshake and packet outputs)
//
//   Parameters
//     CMD_ENABLE   command byte sent after reset or on ACK timeout
//     ACK_BYTE     device acknowledge byte
//     ACK_TIMEOUT  clk cycles spent waiting for the ACK before resending
//     PKT_TIMEOUT  max clk cycles between bytes of one packet
// ----------------------------------------------------------------------------
module ps2_mouse_ctrl #(
  parameter logic [7:0] CMD_ENABLE  = 8'hF4,
  parameter logic [7:0] ACK_BYTE    = 8'hFA,
  parameter int         ACK_TIMEOUT = 2_000_000,
  parameter int         PKT_TIMEOUT = 200_000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  ps2_mouse_ctrl_if.master bus
);

  localparam int TMAX = (ACK_TIMEOUT > PKT_TIMEOUT) ? ACK_TIMEOUT : PKT_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] PKT_LAST = TW'(PKT_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  typedef enum logic [2:0] {
    SEND,
    WAIT_TX,
    WAIT_ACK,
    PKT1,
    PKT2,
    PKT3
  } state_t;

  state_t        state_reg;
  logic [TW-1:0] timer_reg;

  // Only the fields of byte 1 that are reported are kept: the X/Y sign bits
  // and the buttons. Overflow bits and the sync bit are dropped.
  logic          sign_x_reg;
  logic          sign_y_reg;
  logic [2:0]    btn1_reg;
  logic [7:0]    byte2_reg;

  logic          tx_en_reg;
  logic [7:0]    tx_data_reg;
  logic [8:0]    xm_reg;
  logic [8:0]    ym_reg;
  logic [2:0]    btn_reg;
  logic          init_done_reg;
  logic          done_reg;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg     <= SEND;
      timer_reg     <= '0;
      sign_x_reg    <= 1'b0;
      sign_y_reg    <= 1'b0;
      btn1_reg      <= 3'b000;
      byte2_reg     <= 8'h00;
      tx_en_reg     <= 1'b0;
      tx_data_reg   <= CMD_ENABLE;
      xm_reg        <= 9'h000;
      ym_reg        <= 9'h000;
      btn_reg       <= 3'b000;
      init_done_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      // Strobes default low so each one lasts exactly one cycle.
      tx_en_reg   <= 1'b0;
      done_reg    <= 1'b0;
      tx_data_reg <= CMD_ENABLE;

      case (state_reg)
        // One cycle here raises the registered tx request, which is then
        // visible during the first WAIT_TX cycle.
        SEND: begin
          tx_en_reg <= 1'b1;
          timer_reg <= '0;
          state_reg <= WAIT_TX;
        end

        // Bytes arriving while the command is still going out are ignored.
        WAIT_TX: begin
          timer_reg <= '0;
          if (bus.tx_done_i) begin
            state_reg <= WAIT_ACK;
          end
        end

        // Any received byte restarts the ACK window; only ACK_BYTE finishes
        // initialisation. A received byte beats a simultaneous expiry.
        WAIT_ACK: begin
          if (bus.rx_done_i) begin
            timer_reg <= '0;
            if (bus.rx_data_i == ACK_BYTE) begin
              init_done_reg <= 1'b1;
              state_reg     <= PKT1;
            end
          end else if (timer_reg == ACK_LAST) begin
            timer_reg <= '0;
            state_reg <= SEND;
          end else begin
            timer_reg <= timer_reg + TIMER_ONE;
          end
        end

        // Byte 1 always has bit 3 set; anything else is skipped so the
        // stream realigns on its own. No timeout while idle between packets.
        PKT1: begin
          timer_reg <= '0;
          if (bus.rx_done_i && bus.rx_data_i[3]) begin
            sign_x_reg <= bus.rx_data_i[4];
            sign_y_reg <= bus.rx_data_i[5];
            btn1_reg   <= bus.rx_data_i[2:0];
            state_reg  <= PKT2;
          end
        end

        PKT2: begin
          if (bus.rx_done_i) begin
            byte2_reg <= bus.rx_data_i;
            timer_reg <= '0;
            state_reg <= PKT3;
          end else if (timer_reg == PKT_LAST) begin
            timer_reg <= '0;
            state_reg <= PKT1;
          end else begin
            timer_reg <= timer_reg + TIMER_ONE;
          end
        end

        // Byte 3 is consumed straight from the bus, so the full packet
        // appears on the outputs one edge after the third strobe.
        PKT3: begin
          if (bus.rx_done_i) begin
            xm_reg    <= {sign_x_reg, byte2_reg};
            ym_reg    <= {sign_y_reg, bus.rx_data_i};
            btn_reg   <= btn1_reg;
            done_reg  <= 1'b1;
            timer_reg <= '0;
            state_reg <= PKT1;
          end else if (timer_reg == PKT_LAST) begin
            timer_reg <= '0;
            state_reg <= PKT1;
          end else begin
            timer_reg <= timer_reg + TIMER_ONE;
          end
        end

        default: begin
          timer_reg <= '0;
          state_reg <= SEND;
        end
      endcase
    end
  end

  assign bus.tx_en_o     = tx_en_reg;
  assign bus.tx_data_o   = tx_data_reg;
  assign bus.xm_o        = xm_reg;
  assign bus.ym_o        = ym_reg;
  assign bus.btn_o       = btn_reg;
  assign bus.init_done_o = init_done_reg;
  assign bus.done_o      = done_reg;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ps2_mouse_ctrl
//   Directed init/ACK/timeout steps followed by directed and random packet
//   streams, checked against a packet-level reference model.
// ----------------------------------------------------------------------------
module tb_ps2_mouse_ctrl;
  localparam int ACK_TO = 50;
  localparam int PKT_TO = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_mouse_ctrl_if bus ();

  ps2_mouse_ctrl #(
    .CMD_ENABLE (8'hF4),
    .ACK_BYTE   (8'hFA),
    .ACK_TIMEOUT(ACK_TO),
    .PKT_TIMEOUT(PKT_TO)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int tx_pulses = 0;

  always @(posedge clk) if (bus.tx_en_o === 1'b1) tx_pulses++;

  // Reference model: bytes of the packet in progress and last reported values.
  logic [7:0] pkt_q[$];
  logic [8:0] m_xm  = 9'h000;
  logic [8:0] m_ym  = 9'h000;
  logic [2:0] m_btn = 3'b000;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  // gap = clock edges since the previous byte strobe. A partial packet
  // survives while gap <= PKT_TO (a byte arriving on the expiry edge wins).
  function automatic bit model_byte(logic [7:0] b, int gap);
    int dx;
    int dy;
    if (pkt_q.size() != 0 && gap > PKT_TO) pkt_q.delete();
    if (pkt_q.size() == 0) begin
      if (b[3]) pkt_q.push_back(b);
      return 1'b0;
    end
    pkt_q.push_back(b);
    if (pkt_q.size() == 3) begin
      dx = int'(pkt_q[1]) - (pkt_q[0][4] ? 256 : 0);
      dy = int'(pkt_q[2]) - (pkt_q[0][5] ? 256 : 0);
      m_xm  = dx[8:0];
      m_ym  = dy[8:0];
      m_btn = pkt_q[0][2:0];
      pkt_q.delete();
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Caller is at a negedge. Waits gap_idle cycles, strobes the byte, then
  // checks the outputs half a cycle after the sampling edge.
  task automatic send_byte(logic [7:0] b, int gap_idle, string tag);
    bit exp_done;
    idle(gap_idle);
    exp_done = model_byte(b, gap_idle + 1);
    bus.rx_data_i = b;
    bus.rx_done_i = 1'b1;
    @(negedge clk);
    bus.rx_done_i = 1'b0;
    check({tag, ".done"}, bus.done_o, exp_done);
    check({tag, ".xm"},   bus.xm_o,   m_xm);
    check({tag, ".ym"},   bus.ym_o,   m_ym);
    check({tag, ".btn"},  bus.btn_o,  m_btn);
    $display("pkt byte %s data=%02h done=%0b xm=%03h ym=%03h btn=%03b",
             tag, b, bus.done_o, bus.xm_o, bus.ym_o, bus.btn_o);
  endtask

  // Strobe a byte without involving the packet model (init phase).
  task automatic raw_rx(logic [7:0] b);
    bus.rx_data_i = b;
    bus.rx_done_i = 1'b1;
    @(negedge clk);
    bus.rx_done_i = 1'b0;
    $display("init rx byte %02h init_done=%0b", b, bus.init_done_o);
  endtask

  task automatic pulse_tx_done();
    bus.tx_done_i = 1'b1;
    @(negedge clk);
    bus.tx_done_i = 1'b0;
    $display("tx_done pulse");
  endtask

  task automatic check_reset_values(string tag);
    check({tag, ".tx_en"},     bus.tx_en_o,     1'b0);
    check({tag, ".tx_data"},   bus.tx_data_o,   8'hF4);
    check({tag, ".xm"},        bus.xm_o,        9'h000);
    check({tag, ".ym"},        bus.ym_o,        9'h000);
    check({tag, ".btn"},       bus.btn_o,       3'b000);
    check({tag, ".init_done"}, bus.init_done_o, 1'b0);
    check({tag, ".done"},      bus.done_o,      1'b0);
  endtask

  initial begin
    int seen;
    int snap;
    logic [7:0] rb;
    int rg;

    bus.rx_data_i = 8'h00;
    bus.rx_done_i = 1'b0;
    bus.tx_done_i = 1'b0;
    rst = 1'b1;
    idle(3);
    check_reset_values("reset");

    // Command goes out once, as a single-cycle request.
    rst = 1'b0;
    @(negedge clk);
    check("first_cmd.tx_en", bus.tx_en_o, 1'b1);
    check("first_cmd.tx_data", bus.tx_data_o, 8'hF4);
    @(negedge clk);
    check("first_cmd.one_cycle", bus.tx_en_o, 1'b0);

    // An ACK arriving before tx_done is ignored.
    raw_rx(8'hFA);
    check("wait_tx.ignores_rx", bus.init_done_o, 1'b0);

    // No ACK: 50 cycles in WAIT_ACK, one SEND cycle, then the registered
    // request shows up, i.e. ACK_TO+1 cycles after WAIT_ACK entry.
    pulse_tx_done();
    seen = -1;
    for (int k = 1; k <= ACK_TO + 10; k++) begin
      @(negedge clk);
      if (bus.tx_en_o === 1'b1) begin
        seen = k;
        break;
      end
    end
    check("ack_timeout.resend_cycle", seen, ACK_TO + 1);
    $display("resend observed after %0d cycles", seen);
    idle(1);
    check("resend.one_cycle", bus.tx_en_o, 1'b0);

    pulse_tx_done();
    raw_rx(8'hAA);
    check("ack.non_ack_ignored", bus.init_done_o, 1'b0);
    raw_rx(8'hFA);
    check("ack.init_done", bus.init_done_o, 1'b1);

    // No further transmission after init, even with a stray tx_done.
    snap = tx_pulses;
    idle(ACK_TO + 10);
    pulse_tx_done();
    idle(5);
    check("post_init.no_tx", tx_pulses, snap);
    check("post_init.init_held", bus.init_done_o, 1'b1);

    // Directed packets.
    send_byte(8'h19, 0, "p1.b1");
    send_byte(8'h05, 2, "p1.b2");
    send_byte(8'hFE, 3, "p1.b3");
    check("p1.const_xm", bus.xm_o, 9'h105);
    check("p1.const_ym", bus.ym_o, 9'h0FE);
    check("p1.const_btn", bus.btn_o, 3'b001);
    idle(1);
    check("p1.done_one_cycle", bus.done_o, 1'b0);

    send_byte(8'h00, 1, "p2.nosync");
    send_byte(8'h08, 1, "p2.b1");
    send_byte(8'h10, 1, "p2.b2");
    send_byte(8'h20, 1, "p2.b3");
    check("p2.const_xm", bus.xm_o, 9'h010);
    check("p2.const_ym", bus.ym_o, 9'h020);
    check("p2.const_btn", bus.btn_o, 3'b000);

    // Partial packet dropped after PKT_TO idle cycles in PKT3.
    send_byte(8'h08, 1, "p3.b1");
    send_byte(8'h01, 0, "p3.b2");
    send_byte(8'h0A, PKT_TO, "p3.new_b1");
    send_byte(8'h02, 0, "p3.b2b");
    send_byte(8'h03, 0, "p3.b3");
    check("p3.const_xm", bus.xm_o, 9'h002);
    check("p3.const_ym", bus.ym_o, 9'h003);
    check("p3.const_btn", bus.btn_o, 3'b010);

    // Byte landing on the expiry edge is still accepted.
    send_byte(8'h08, 1, "p4.b1");
    send_byte(8'h01, 0, "p4.b2");
    send_byte(8'h7F, PKT_TO - 1, "p4.b3_edge");
    check("p4.const_ym", bus.ym_o, 9'h07F);

    // Timeout in PKT2.
    send_byte(8'h08, 1, "p5.b1");
    send_byte(8'h09, PKT_TO, "p5.new_b1");
    send_byte(8'h11, 0, "p5.b2");
    send_byte(8'h22, 0, "p5.b3");
    check("p5.const_xm", bus.xm_o, 9'h011);
    check("p5.const_btn", bus.btn_o, 3'b001);

    // Random stream with occasional long gaps around the timeout.
    for (int i = 0; i < 300; i++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rb[3] = 1'b1;
      if ($urandom_range(0, 9) == 0) rg = $urandom_range(PKT_TO - 2, PKT_TO + 3);
      else rg = $urandom_range(0, 4);
      send_byte(rb, rg, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset while in PKT2.
    send_byte(8'h08, PKT_TO + 2, "r.b1");
    send_byte(8'h3C, 0, "r.b2");
    send_byte(8'h7E, 0, "r.b3");
    send_byte(8'h08, 1, "r.pkt2");
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    pkt_q.delete();
    m_xm  = 9'h000;
    m_ym  = 9'h000;
    m_btn = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart.tx_en", bus.tx_en_o, 1'b1);
    idle(1);
    pulse_tx_done();
    raw_rx(8'hFA);
    check("restart.init_done", bus.init_done_o, 1'b1);
    send_byte(8'h2C, 1, "after.b1");
    send_byte(8'h80, 1, "after.b2");
    send_byte(8'h01, 1, "after.b3");
    check("after.const_xm", bus.xm_o, 9'h080);
    check("after.const_ym", bus.ym_o, 9'h101);
    check("after.const_btn", bus.btn_o, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
